or_input_debounce: RTL

//  Two-channel push-button conditioner placed directly upstream of the 2-input OR gate.
//  It takes raw, asynchronous, bouncing board buttons and passes each through a
//  2-flop synchroniser and then a stability counter.
//  It drives clean, glitch-free levels to the gate's a/b inputs, plus one-cycle

---
 rtl/or_input_debounce.sv | 93 +++++++++
 1 files changed

// File: rtl/or_input_debounce.sv
// Two-channel button conditioner feeding the OR gate inputs: each raw button is
// synchronised, then debounced by a stability counter, with a rising-edge pulse.
module or_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a_clean,
  output logic b_clean,
  output logic a_rise,
  output logic b_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    STABLE_0 = 1'b0,
    STABLE_1 = 1'b1
  } state_t;

  logic [1:0] raw_s;
  logic [1:0] clean_s;
  logic [1:0] rise_s;

  assign raw_s = {btn_b_raw, btn_a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : gen_ch
    logic             sync1_r;
    logic             sync2_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;

    // Synchroniser plus stability FSM; a bounce back to the held level clears progress.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
        rise_r  <= 1'b0;
        cnt_r   <= '0;
        state_r <= STABLE_0;
      end else begin
        sync1_r <= raw_s[ch];
        sync2_r <= sync1_r;
        rise_r  <= 1'b0;
        case (state_r)
          STABLE_0: begin
            if (sync2_r == 1'b1) begin
              if (cnt_r == CNT_MAX) begin
                state_r <= STABLE_1;
                cnt_r   <= '0;
                rise_r  <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else begin
              cnt_r <= '0;
            end
          end
          STABLE_1: begin
            if (sync2_r == 1'b0) begin
              if (cnt_r == CNT_MAX) begin
                state_r <= STABLE_0;
                cnt_r   <= '0;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else begin
              cnt_r <= '0;
            end
          end
          default: begin
            state_r <= STABLE_0;
            cnt_r   <= '0;
          end
        endcase
      end
    end

    assign clean_s[ch] = (state_r == STABLE_1);
    assign rise_s[ch]  = rise_r;
  end

  assign a_clean = clean_s[0];
  assign b_clean = clean_s[1];
  assign a_rise  = rise_s[0];
  assign b_rise  = rise_s[1];

endmodule
